// File: rtl/uart_rx_if.sv
// Receive-side bundle for uart_rx: serial line in, byte/valid/error pulses out.
// slave  = the receiver itself; master = whoever drives the line and consumes bytes.
interface uart_rx_if;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       parity_err;
  logic       rx_busy;

  modport master (
    output rx,
    input  rx_data, rx_valid, frame_err, parity_err, rx_busy
  );

  modport slave (
    input  rx,
    output rx_data, rx_valid, frame_err, parity_err, rx_busy
  );
endinterface

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver on sys_clk_100M, byte presented with a one-cycle
// rx_valid pulse, stop-bit violations on frame_err.
// Optional build macro UART_RX_PARITY_EN adds a parity bit (8E1/8O1 via
// PARITY_ODD) and drives parity_err; without it parity_err is constant 0.
module uart_rx #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic     sys_clk_100M,
  input  logic     rst,
  uart_rx_if.slave bus
);

  localparam int          BAUD_DIV  = CLK_FREQ / BAUD_RATE;
  localparam int          HALF_DIV  = BAUD_DIV / 2;
  localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);
  localparam logic [15:0] HALF_LAST = 16'(HALF_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t      state_q, state_d;
  logic        rx_s1_q, rx_s2_q, rx_s3_q;
  logic [15:0] baud_cnt_q;
  logic [2:0]  bit_cnt_q;
  logic [7:0]  shift_q;
  logic [7:0]  rx_data_q;
  logic        rx_valid_q, frame_err_q, parity_err_q;

  logic        fall_edge, baud_tick, half_tick;
  logic        valid_d, ferr_d, perr_d, busy;

  assign fall_edge = rx_s3_q & ~rx_s2_q;
  assign baud_tick = (baud_cnt_q == BAUD_LAST);
  assign half_tick = (baud_cnt_q == HALF_LAST);

`ifdef UART_RX_PARITY_EN
  logic parity_bit_q;
  logic parity_exp;
  // Even parity expects XOR of the data; odd parity expects its complement.
  assign parity_exp = PARITY_ODD ? ~(^shift_q) : (^shift_q);
`else
  logic unused_parity_cfg;
  assign unused_parity_cfg = PARITY_ODD;
`endif

  // Two-flop synchroniser plus a third flop purely for falling-edge detection.
  always_ff @(posedge sys_clk_100M) begin
    if (rst) begin
      rx_s1_q <= 1'b1;
      rx_s2_q <= 1'b1;
      rx_s3_q <= 1'b1;
    end else begin
      rx_s1_q <= bus.rx;
      rx_s2_q <= rx_s1_q;
      rx_s3_q <= rx_s2_q;
    end
  end

  // FSM state register.
  always_ff @(posedge sys_clk_100M) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // FSM next-state: start validation at half bit, then one sample per bit centre.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (fall_edge) state_d = S_START;
      S_START: if (half_tick) state_d = rx_s2_q ? S_IDLE : S_DATA;
      S_DATA: begin
        if (baud_tick && (bit_cnt_q == 3'd7)) begin
`ifdef UART_RX_PARITY_EN
          state_d = S_PARITY;
`else
          state_d = S_STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: if (baud_tick) state_d = S_STOP;
`endif
      S_STOP:  if (baud_tick) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs: the stop-bit-centre decision and the busy flag.
  always_comb begin
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    perr_d  = 1'b0;
    busy    = (state_q != S_IDLE);
    if ((state_q == S_STOP) && baud_tick) begin
`ifdef UART_RX_PARITY_EN
      perr_d = (parity_bit_q != parity_exp);
`endif
      ferr_d  = ~rx_s2_q;
      valid_d = rx_s2_q & ~perr_d;
    end
  end

  // Bit timing, bit counting and the receive shift register.
  always_ff @(posedge sys_clk_100M) begin
    if (rst) begin
      baud_cnt_q <= 16'd0;
      bit_cnt_q  <= 3'd0;
      shift_q    <= 8'h00;
`ifdef UART_RX_PARITY_EN
      parity_bit_q <= 1'b0;
`endif
    end else begin
      if ((state_d != state_q) || (state_q == S_IDLE) || baud_tick) baud_cnt_q <= 16'd0;
      else                                                         baud_cnt_q <= baud_cnt_q + 16'd1;

      if (state_q == S_START) bit_cnt_q <= 3'd0;
      else if ((state_q == S_DATA) && baud_tick) bit_cnt_q <= bit_cnt_q + 3'd1;

      // LSB arrives first, so shifting right leaves bit 0 in shift_q[0].
      if ((state_q == S_DATA) && baud_tick) shift_q <= {rx_s2_q, shift_q[7:1]};
`ifdef UART_RX_PARITY_EN
      if ((state_q == S_PARITY) && baud_tick) parity_bit_q <= rx_s2_q;
`endif
    end
  end

  // Output byte register and the one-cycle result pulses.
  always_ff @(posedge sys_clk_100M) begin
    if (rst) begin
      rx_data_q    <= 8'h00;
      rx_valid_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      rx_valid_q   <= valid_d;
      frame_err_q  <= ferr_d;
      parity_err_q <= perr_d;
      if (valid_d) rx_data_q <= shift_q;
    end
  end

  assign bus.rx_data    = rx_data_q;
  assign bus.rx_valid   = rx_valid_q;
  assign bus.frame_err  = frame_err_q;
  assign bus.parity_err = parity_err_q;
  assign bus.rx_busy    = busy;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx, run at a 64-clock bit period to keep frames short.
module tb_uart_rx;
  localparam int BIT  = 64;
  localparam int HALF = 32;
`ifdef UART_RX_PARITY_EN
  localparam int LAT_MIN = 672 + 3;
`else
  localparam int LAT_MIN = 608 + 3;
`endif
  localparam int LAT_MAX = LAT_MIN + 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   start_cyc = 0;

  uart_rx_if bus ();

  uart_rx #(
    .CLK_FREQ  (100_000_000),
    .BAUD_RATE (1_562_500),
    .PARITY_ODD(1'b0)
  ) dut (
    .sys_clk_100M(clk),
    .rst         (rst),
    .bus         (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor
  logic [7:0] got [0:63];
  int         vcyc [0:63];
  int         vc = 0, fc = 0, pc = 0, bc = 0, wide = 0, overlap = 0;
  logic       pv = 1'b0, pf = 1'b0, pp = 1'b0;

  always @(negedge clk) begin
    if (bus.rx_valid === 1'b1 && vc < 64) begin
      got[vc]  = bus.rx_data;
      vcyc[vc] = cyc;
      vc++;
    end
    if (bus.frame_err === 1'b1)  fc++;
    if (bus.parity_err === 1'b1) pc++;
    if (bus.rx_busy === 1'b1)    bc++;
    if ((bus.rx_valid === 1'b1 && pv) || (bus.frame_err === 1'b1 && pf) ||
        (bus.parity_err === 1'b1 && pp)) wide++;
    if (bus.rx_valid === 1'b1 && (bus.frame_err === 1'b1 || bus.parity_err === 1'b1)) overlap++;
    pv = (bus.rx_valid === 1'b1);
    pf = (bus.frame_err === 1'b1);
    pp = (bus.parity_err === 1'b1);
  end

  task automatic wait_cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drive_bit(input logic v);
    bus.rx = v;
    wait_cyc(BIT);
  endtask

  // Frame with selectable stop level; par_flip inverts the (even) parity bit.
  task automatic send_frame(input logic [7:0] d, input logic stop, input logic par_flip);
    start_cyc = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit((^d) ^ par_flip);
`else
    if (par_flip) $display("note: parity flip ignored in 8N1 build");
`endif
    drive_bit(stop);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    wait_cyc(3);
    @(negedge clk);
    total++; if (bus.rx_data !== 8'h00) begin bad++; $display("FAIL reset_data got=%h want=00", bus.rx_data); end
    total++; if (bus.rx_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", bus.rx_valid); end
    total++; if (bus.frame_err !== 1'b0) begin bad++; $display("FAIL reset_ferr got=%b want=0", bus.frame_err); end
    total++; if (bus.parity_err !== 1'b0) begin bad++; $display("FAIL reset_perr got=%b want=0", bus.parity_err); end
    total++; if (bus.rx_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", bus.rx_busy); end
    @(posedge clk); #1;
    rst = 1'b0;
    wait_cyc(10);
  endtask

  task automatic test_single;
    int b0, f0, lat;
    b0 = vc; f0 = fc;
    send_frame(8'h55, 1'b1, 1'b0);
    wait_cyc(BIT);
    total++; if (vc - b0 !== 1) begin bad++; $display("FAIL single_count got=%0d want=1", vc - b0); end
    total++; if (bus.rx_data !== 8'h55) begin bad++; $display("FAIL single_data got=%h want=55", bus.rx_data); end
    lat = (vc > b0) ? (vcyc[b0] - start_cyc) : -1;
    total++; if (lat < LAT_MIN || lat > LAT_MAX) begin bad++; $display("FAIL single_latency got=%0d want=%0d..%0d", lat, LAT_MIN, LAT_MAX); end
    total++; if (fc !== f0) begin bad++; $display("FAIL single_ferr got=%0d want=0", fc - f0); end
  endtask

  task automatic test_back_to_back;
    int b0;
    logic [7:0] exp [0:2];
    exp[0] = 8'h00; exp[1] = 8'hFF; exp[2] = 8'hA3;
    b0 = vc;
    for (int i = 0; i < 3; i++) send_frame(exp[i], 1'b1, 1'b0);
    wait_cyc(2 * BIT);
    total++; if (vc - b0 !== 3) begin bad++; $display("FAIL b2b_count got=%0d want=3", vc - b0); end
    for (int i = 0; i < 3; i++) begin
      total++;
      if (vc - b0 <= i || got[b0 + i] !== exp[i]) begin
        bad++; $display("FAIL b2b_byte%0d got=%h want=%h", i, (vc - b0 > i) ? got[b0 + i] : 8'hxx, exp[i]);
      end
    end
  endtask

  task automatic test_glitch;
    int b0, f0, busy0;
    b0 = vc; f0 = fc; busy0 = bc;
    bus.rx = 1'b0;
    wait_cyc(20);
    bus.rx = 1'b1;
    wait_cyc(4 * BIT);
    total++; if (vc !== b0) begin bad++; $display("FAIL glitch_valid got=%0d want=0", vc - b0); end
    total++; if (fc !== f0) begin bad++; $display("FAIL glitch_ferr got=%0d want=0", fc - f0); end
    total++; if (bc - busy0 !== HALF) begin bad++; $display("FAIL glitch_busy_cycles got=%0d want=%0d", bc - busy0, HALF); end
    @(negedge clk);
    total++; if (bus.rx_busy !== 1'b0) begin bad++; $display("FAIL glitch_idle got=%b want=0", bus.rx_busy); end
    @(posedge clk); #1;
  endtask

  task automatic test_frame_err;
    int b0, f0;
    send_frame(8'h55, 1'b1, 1'b0);
    b0 = vc; f0 = fc;
    send_frame(8'h3C, 1'b0, 1'b0);
    wait_cyc(3 * BIT);
    total++; if (fc - f0 !== 1) begin bad++; $display("FAIL ferr_count got=%0d want=1", fc - f0); end
    total++; if (vc !== b0) begin bad++; $display("FAIL ferr_valid got=%0d want=0", vc - b0); end
    total++; if (bus.rx_data !== 8'h55) begin bad++; $display("FAIL ferr_data_hold got=%h want=55", bus.rx_data); end
    drive_bit(1'b1);
    send_frame(8'h81, 1'b1, 1'b0);
    wait_cyc(BIT);
    total++; if (bus.rx_data !== 8'h81) begin bad++; $display("FAIL after_break_data got=%h want=81", bus.rx_data); end
    total++; if (vc - b0 !== 1) begin bad++; $display("FAIL after_break_count got=%0d want=1", vc - b0); end
  endtask

  task automatic test_reset_mid;
    int b0, f0;
    logic [7:0] d;
    d = 8'h96;
    b0 = vc; f0 = fc;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(d[i]);
    bus.rx = d[4];
    wait_cyc(HALF);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    total++; if (bus.rx_data !== 8'h00) begin bad++; $display("FAIL midrst_data got=%h want=00", bus.rx_data); end
    total++; if (bus.rx_busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b want=0", bus.rx_busy); end
    @(posedge clk); #1;
    bus.rx = 1'b1;
    wait_cyc(12 * BIT);
    total++; if (vc !== b0 || fc !== f0) begin bad++; $display("FAIL midrst_pulse got=v%0d/f%0d want=0/0", vc - b0, fc - f0); end
    send_frame(8'h5A, 1'b1, 1'b0);
    wait_cyc(BIT);
    total++; if (bus.rx_data !== 8'h5A) begin bad++; $display("FAIL midrst_next_data got=%h want=5a", bus.rx_data); end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity;
    int b0, p0;
    b0 = vc; p0 = pc;
    send_frame(8'h07, 1'b1, 1'b0);
    wait_cyc(BIT);
    total++; if (vc - b0 !== 1 || bus.rx_data !== 8'h07) begin bad++; $display("FAIL parity_good got=n%0d/%h want=1/07", vc - b0, bus.rx_data); end
    send_frame(8'h07, 1'b1, 1'b1);
    wait_cyc(BIT);
    total++; if (pc - p0 !== 1) begin bad++; $display("FAIL parity_err_count got=%0d want=1", pc - p0); end
    total++; if (vc - b0 !== 1) begin bad++; $display("FAIL parity_bad_valid got=%0d want=1", vc - b0); end
  endtask
`endif

  task automatic test_pulse_rules;
    total++; if (wide !== 0) begin bad++; $display("FAIL pulse_width got=%0d want=0", wide); end
    total++; if (overlap !== 0) begin bad++; $display("FAIL pulse_overlap got=%0d want=0", overlap); end
`ifndef UART_RX_PARITY_EN
    total++; if (pc !== 0) begin bad++; $display("FAIL parity_tied got=%0d want=0", pc); end
`endif
  endtask

  initial begin
    bus.rx = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_reset_mid();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    test_pulse_rules();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
